// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared types and constants for the AES request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Nominal aes_core load-to-done latency in cycles
  localparam int AES_CORE_LATENCY = 88;

  // Width of an index into n requesters (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first set request bit at or
//               above ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import aes_pkg::*;
#(
  parameter int N = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  localparam logic [IW:0] C_N = N[IW:0];

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_sh;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  // Rotate requests so that bit 0 corresponds to the requester at ptr
  assign w_dbl = {req, req};
  assign w_sh  = w_dbl >> ptr;
  assign w_rot = w_sh[N-1:0];

  // Lowest set bit of the rotated vector is the distance from ptr to the grant
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
  end

  // Undo the rotation modulo N
  always_comb begin
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= C_N) grant = IW'(w_sum - C_N);
    else              grant = w_sum[IW-1:0];
  end

  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/aes_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aes_request_arbiter
// Description : Shares one aes_core among N requesters. Round-robin grant,
//               one-cycle core load, watchdog on core done, and a valid/ready
//               response carrying ciphertext or a timeout error.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_request_arbiter
  import aes_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic [N*128-1:0] req_key,
  input  logic [N*128-1:0] req_plaintext,
  output logic [N-1:0]     req_ack,
  output logic [N-1:0]     rsp_valid,
  input  logic [N-1:0]     rsp_ready,
  output logic [127:0]     rsp_ciphertext,
  output logic             rsp_error,
  output logic             busy,
  output logic             core_load,
  output logic             core_reset,
  output logic [127:0]     core_key,
  output logic [127:0]     core_plaintext,
  input  logic             core_done,
  input  logic [127:0]     core_ciphertext
);

  localparam int              IW        = idx_width(N);
  localparam int              CW        = $clog2(TIMEOUT);
  localparam logic [IW-1:0]   C_LAST    = IW'(N - 1);
  localparam logic [CW-1:0]   C_TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [N-1:0]    C_ONE     = 1;

  arb_state_t     state_q;
  logic [IW-1:0]  ptr_q;
  logic [IW-1:0]  grant_q;
  logic [127:0]   key_q;
  logic [127:0]   pt_q;
  logic [127:0]   ct_q;
  logic           err_q;
  logic [CW-1:0]  cnt_q;

  logic [IW-1:0]  w_grant;
  logic           w_any;
  logic           w_timeout;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (w_grant),
    .any   (w_any)
  );

  // Watchdog fires on the last allowed WAIT cycle unless done arrives with it
  assign w_timeout = (state_q == WAIT) && !core_done && (cnt_q == C_TO_LAST);

  // Arbiter FSM, datapath capture and watchdog counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_any) begin
            grant_q <= w_grant;
            key_q   <= req_key[128*w_grant +: 128];
            pt_q    <= req_plaintext[128*w_grant +: 128];
            state_q <= LOAD;
          end
        end
        LOAD: begin
          // done may linger from the previous operation; it is not looked at here
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (core_done) begin
            ct_q    <= core_ciphertext;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (w_timeout) begin
            ct_q    <= '0;
            err_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[grant_q]) begin
            ptr_q   <= (grant_q == C_LAST) ? '0 : grant_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode; the ack is masked during reset so every output stays 0
  always_comb begin
    req_ack        = (reset_n && state_q == IDLE && w_any) ? (C_ONE << w_grant) : '0;
    rsp_valid      = (state_q == RESP) ? (C_ONE << grant_q) : '0;
    rsp_ciphertext = (state_q == RESP) ? ct_q : '0;
    rsp_error      = (state_q == RESP) ? err_q : 1'b0;
    busy           = (state_q != IDLE);
    core_load      = (state_q == LOAD);
    core_reset     = !reset_n || w_timeout;
    core_key       = key_q;
    core_plaintext = pt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_request_arbiter
// Description : Directed bench for aes_request_arbiter with an aes_core stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_request_arbiter;
  import aes_pkg::*;

  localparam int N = 2;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*128-1:0] req_key = '0;
  logic [N*128-1:0] req_plaintext = '0;
  logic [N-1:0]     req_ack;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready = '0;
  logic [127:0]     rsp_ciphertext;
  logic             rsp_error;
  logic             busy;
  logic             core_load;
  logic             core_reset;
  logic [127:0]     core_key;
  logic [127:0]     core_plaintext;
  logic             core_done = 1'b0;
  logic [127:0]     core_ciphertext = '0;

  int errors = 0;
  int checks = 0;
  int load_cnt = 0;

  aes_request_arbiter #(.N(N), .TIMEOUT(255)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req             (req),
    .req_key         (req_key),
    .req_plaintext   (req_plaintext),
    .req_ack         (req_ack),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_ciphertext  (rsp_ciphertext),
    .rsp_error       (rsp_error),
    .busy            (busy),
    .core_load       (core_load),
    .core_reset      (core_reset),
    .core_key        (core_key),
    .core_plaintext  (core_plaintext),
    .core_done       (core_done),
    .core_ciphertext (core_ciphertext)
  );

  always #5 clk = ~clk;

  // aes_core stub: known-answer table, fixed latency, optional hang
  logic         stub_hang = 1'b0;
  logic         stub_run = 1'b0;
  int           stub_cnt = 0;
  logic [127:0] stub_key = '0;
  logic [127:0] stub_pt = '0;

  function automatic logic [127:0] kat(input logic [127:0] k, input logic [127:0] p);
    if (k == K1 && p == P1) return C1;
    if (k == K2 && p == P2) return C2;
    return 128'hbad0_bad0;
  endfunction

  always @(posedge clk) begin
    if (core_reset) begin
      core_done <= 1'b0;
      stub_run  <= 1'b0;
    end else if (core_load) begin
      core_done <= 1'b0;
      stub_run  <= 1'b1;
      stub_cnt  <= AES_CORE_LATENCY - 1;
      stub_key  <= core_key;
      stub_pt   <= core_plaintext;
      load_cnt  <= load_cnt + 1;
    end else if (stub_run && !stub_hang) begin
      if (stub_cnt == 0) begin
        core_done       <= 1'b1;
        core_ciphertext <= kat(stub_key, stub_pt);
        stub_run        <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  task automatic set_req(input int idx, input logic [127:0] k, input logic [127:0] p);
    req_key[128*idx +: 128]       = k;
    req_plaintext[128*idx +: 128] = p;
  endtask

  task automatic wait_valid(input int idx, inout int cyc, input int limit);
    while (!rsp_valid[idx] && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake(input int idx);
    rsp_ready[idx] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 2'b01;
    set_req(0, K1, P1);
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ack, rsp_valid, rsp_ciphertext, rsp_error, busy, core_load, core_key, core_plaintext} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b valid=%b busy=%b load=%b key=%h expected all zero",
               req_ack, rsp_valid, busy, core_load, core_key);
    end
    checks++;
    if (core_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_core_reset: got %b expected 1", core_reset);
    end
    req = '0;
    reset_n = 1'b1;
    #1;
    checks++;
    if ({core_reset, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got core_reset=%b busy=%b expected 0 0", core_reset, busy);
    end
  endtask

  task automatic test_single(input int idx, input logic [127:0] k, input logic [127:0] p,
                             input logic [127:0] exp_ct);
    int cyc;
    logic [N-1:0] exp_oh;
    exp_oh = '0;
    exp_oh[idx] = 1'b1;
    @(negedge clk);
    set_req(idx, k, p);
    req[idx] = 1'b1;
    #1;
    checks++;
    if (req_ack !== exp_oh) begin
      errors++;
      $display("FAIL single%0d_ack: got %b expected %b", idx, req_ack, exp_oh);
    end
    @(negedge clk);
    req = '0;
    checks++;
    if ({core_load, req_ack, core_key, core_plaintext} !== {1'b1, 2'b00, k, p}) begin
      errors++;
      $display("FAIL single%0d_load: got load=%b ack=%b key=%h pt=%h expected 1 00 %h %h",
               idx, core_load, req_ack, core_key, core_plaintext, k, p);
    end
    @(negedge clk);
    checks++;
    if (core_load !== 1'b0) begin
      errors++;
      $display("FAIL single%0d_load_once: got %b expected 0", idx, core_load);
    end
    cyc = 2;
    wait_valid(idx, cyc, 400);
    checks++;
    if (cyc !== 91) begin
      errors++;
      $display("FAIL single%0d_latency: got %0d cycles expected 91", idx, cyc);
    end
    checks++;
    if ({rsp_valid, rsp_ciphertext, rsp_error} !== {exp_oh, exp_ct, 1'b0}) begin
      errors++;
      $display("FAIL single%0d_rsp: got valid=%b ct=%h err=%b expected %b %h 0",
               idx, rsp_valid, rsp_ciphertext, rsp_error, exp_oh, exp_ct);
    end
    handshake(idx);
    checks++;
    if ({rsp_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL single%0d_done: got valid=%b busy=%b expected 00 0", idx, rsp_valid, busy);
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    @(negedge clk);
    set_req(0, K1, P1);
    set_req(1, K2, P2);
    req = 2'b11;
    #1;
    checks++;
    if (req_ack !== 2'b01) begin
      errors++;
      $display("FAIL simul_first_ack: got %b expected 01", req_ack);
    end
    @(negedge clk);
    req[0] = 1'b0;
    cyc = 0;
    wait_valid(0, cyc, 400);
    checks++;
    if ({rsp_valid, rsp_ciphertext} !== {2'b01, C1}) begin
      errors++;
      $display("FAIL simul_rsp0: got valid=%b ct=%h expected 01 %h", rsp_valid, rsp_ciphertext, C1);
    end
    handshake(0);
    checks++;
    if ({req_ack, busy} !== {2'b10, 1'b0}) begin
      errors++;
      $display("FAIL simul_b2b_ack1: got ack=%b busy=%b expected 10 0", req_ack, busy);
    end
    @(negedge clk);
    req[1] = 1'b0;
    cyc = 0;
    wait_valid(1, cyc, 400);
    checks++;
    if ({rsp_valid, rsp_ciphertext} !== {2'b10, C2}) begin
      errors++;
      $display("FAIL simul_rsp1: got valid=%b ct=%h expected 10 %h", rsp_valid, rsp_ciphertext, C2);
    end
    handshake(1);
    // Serve requester 0 alone so the pointer moves to requester 1
    req[0] = 1'b1;
    @(negedge clk);
    req = '0;
    cyc = 0;
    wait_valid(0, cyc, 400);
    handshake(0);
    req = 2'b11;
    #1;
    checks++;
    if (req_ack !== 2'b10) begin
      errors++;
      $display("FAIL rr_rotate_ack: got %b expected 10", req_ack);
    end
    @(negedge clk);
    req[1] = 1'b0;
    cyc = 0;
    wait_valid(1, cyc, 400);
    checks++;
    if ({rsp_valid, rsp_ciphertext} !== {2'b10, C2}) begin
      errors++;
      $display("FAIL rr_rotate_rsp1: got valid=%b ct=%h expected 10 %h", rsp_valid, rsp_ciphertext, C2);
    end
    handshake(1);
    checks++;
    if (req_ack !== 2'b01) begin
      errors++;
      $display("FAIL rr_rotate_ack0: got %b expected 01", req_ack);
    end
    @(negedge clk);
    req = '0;
    cyc = 0;
    wait_valid(0, cyc, 400);
    checks++;
    if ({rsp_valid, rsp_ciphertext} !== {2'b01, C1}) begin
      errors++;
      $display("FAIL rr_rotate_rsp0: got valid=%b ct=%h expected 01 %h", rsp_valid, rsp_ciphertext, C1);
    end
    handshake(0);
  endtask

  task automatic test_backpressure();
    int cyc;
    int loads0;
    bit stable;
    req[1] = 1'b1;
    @(negedge clk);
    req = '0;
    cyc = 0;
    wait_valid(1, cyc, 400);
    loads0 = load_cnt;
    req[0] = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b10 || rsp_ciphertext !== C2 || req_ack !== 2'b00) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL bp_stable: got valid=%b ct=%h ack=%b expected 10 %h 00",
               rsp_valid, rsp_ciphertext, req_ack, C2);
    end
    checks++;
    if (load_cnt !== loads0) begin
      errors++;
      $display("FAIL bp_no_load: got %0d loads expected %0d", load_cnt, loads0);
    end
    handshake(1);
    checks++;
    if ({req_ack, rsp_valid} !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release: got ack=%b valid=%b expected 01 00", req_ack, rsp_valid);
    end
    @(negedge clk);
    req = '0;
    cyc = 0;
    wait_valid(0, cyc, 400);
    checks++;
    if ({rsp_valid, rsp_ciphertext} !== {2'b01, C1}) begin
      errors++;
      $display("FAIL bp_next_rsp: got valid=%b ct=%h expected 01 %h", rsp_valid, rsp_ciphertext, C1);
    end
    handshake(0);
  endtask

  task automatic test_hung();
    int cyc;
    stub_hang = 1'b1;
    req[0] = 1'b1;
    #1;
    @(negedge clk);
    req = '0;
    cyc = 1;
    while (!core_reset && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 256) begin
      errors++;
      $display("FAIL hung_reset_cycle: got core_reset in cycle %0d expected 256", cyc);
    end
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL hung_no_early_rsp: got valid=%b expected 00", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({core_reset, rsp_valid, rsp_error, rsp_ciphertext} !== {1'b0, 2'b01, 1'b1, 128'h0}) begin
      errors++;
      $display("FAIL hung_rsp: got core_reset=%b valid=%b err=%b ct=%h expected 0 01 1 0",
               core_reset, rsp_valid, rsp_error, rsp_ciphertext);
    end
    handshake(0);
    stub_hang = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int cyc;
    bit seen;
    set_req(0, K2, P2);
    req[0] = 1'b1;
    @(negedge clk);
    req = '0;
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    req[0] = 1'b1;
    #1;
    checks++;
    if ({req_ack, rsp_valid, rsp_ciphertext, rsp_error, busy, core_load, core_key, core_plaintext} !== '0) begin
      errors++;
      $display("FAIL midwait_reset_outputs: got ack=%b valid=%b busy=%b load=%b key=%h expected all zero",
               req_ack, rsp_valid, busy, core_load, core_key);
    end
    checks++;
    if (core_reset !== 1'b1) begin
      errors++;
      $display("FAIL midwait_core_reset: got %b expected 1", core_reset);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00 || req_ack !== 2'b00) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midwait_no_rsp: got activity during reset expected none");
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (req_ack !== 2'b01) begin
      errors++;
      $display("FAIL midwait_rerequest_ack: got %b expected 01", req_ack);
    end
    @(negedge clk);
    req = '0;
    cyc = 1;
    wait_valid(0, cyc, 400);
    checks++;
    if ({cyc, rsp_valid, rsp_ciphertext, rsp_error} !== {32'd91, 2'b01, C2, 1'b0}) begin
      errors++;
      $display("FAIL midwait_recover: got cyc=%0d valid=%b ct=%h err=%b expected 91 01 %h 0",
               cyc, rsp_valid, rsp_ciphertext, rsp_error, C2);
    end
    handshake(0);
  endtask

  initial begin
    test_reset();
    test_single(0, K1, P1, C1);
    test_single(1, K2, P2, C2);
    test_simultaneous();
    test_backpressure();
    test_hung();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/aes_request_arbiter.md
# aes_request_arbiter

Shares one `aes_core` instance between `N` requesters. Each request carries a key and a plaintext, and requests are granted round-robin. The arbiter:
- sequences the core's one-cycle `load`;
- waits for the core's `done` under a timeout watchdog;
- captures the ciphertext and returns it to the granted requester through a valid/ready response handshake.

It sits between the SPI/bus front-ends and `aes_core` in the FPGA top level.

## Interface
Parameters:
- `N`, 2: number of requesters (2–8).
- `TIMEOUT`, 255: WAIT cycles allowed before the core is declared hung. Must exceed the core latency of 88 cycles.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `req` in N: request level per requester. Held until acknowledged.
- `req_key` in N*128: key of requester i is at `[128*i +: 128]`.
- `req_plaintext` in N*128: plaintext, same packing as `req_key`.
- `req_ack` out N: one-cycle pulse when requester i's key and plaintext are captured.
- `rsp_valid` out N: response valid for requester i.
- `rsp_ready` in N: requester i accepts the response.
- `rsp_ciphertext` out 128: shared response data. Meaningful only while some `rsp_valid` bit is high.
- `rsp_error` out 1: qualifies the current response as a timeout. Ciphertext is then 0.
- `busy` out 1: high in every state except IDLE.
- `core_load` out 1: drives `aes_core.load`.
- `core_reset` out 1: drives `aes_core.reset`, which is active-high and synchronous in the core.
- `core_key` out 128: drives `aes_core.key`.
- `core_plaintext` out 128: drives `aes_core.plaintext`.
- `core_done` in 1: from `aes_core.done`.
- `core_ciphertext` in 128: from `aes_core.ciphertext`.

## Operation
- FSM states: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - If any `req` bit is high, choose the grant: the first set bit searching upward from `ptr`, wrapping modulo N.
  - In the same cycle, pulse `req_ack[grant]` and latch that requester's key and plaintext into `key_q`/`pt_q`.
  - Next state is LOAD.
- LOAD:
  - `core_load` = 1 for exactly one cycle.
  - `core_key`/`core_plaintext` = `key_q`/`pt_q`. These are driven in every state.
  - Clear the timeout counter. Next state is WAIT.
  - `core_done` is ignored in LOAD, because it may still be high from the previous operation.
- WAIT:
  - The timeout counter increments every cycle.
  - If `core_done` = 1: capture `core_ciphertext` into `ct_q`, clear `err_q`, go to RESP.
  - Otherwise, if the counter equals TIMEOUT-1: set `ct_q` = 0 and `err_q` = 1, pulse `core_reset` for one cycle, go to RESP.
  - `core_done` takes precedence over the timeout in the same cycle.
- RESP:
  - `rsp_valid[grant]` = 1; all other bits are 0.
  - `rsp_ciphertext` = `ct_q` and `rsp_error` = `err_q`, held stable until the handshake.
  - When `rsp_ready[grant]` = 1: set `ptr` = (grant+1) mod N and go to IDLE.
  - `rsp_ready` bits of non-granted requesters are ignored.
- New requests that arrive during LOAD/WAIT/RESP wait; they are never dropped while `req` is held. A `req` deasserted before its ack is simply not served.
- The arbiter issues a second `core_load` only after the previous response handshake completes, so at most one operation is in flight.

## Timing
- Reset (`reset_n` low, asynchronous):
  - State goes to IDLE; `ptr`, `grant`, `key_q`, `pt_q`, `ct_q`, `err_q` and the counter are all cleared.
  - All outputs are 0 except `core_reset`. `core_reset` = ~`reset_n` OR the timeout pulse, so the core is held in reset throughout.
- Reset mid-operation aborts the operation with no response. Requesters must re-request.
- From a request seen in IDLE:
  - `req_ack` is in cycle 0 and `core_load` in cycle 1.
  - `core_done` is expected in WAIT about 88 cycles later.
  - `rsp_valid` rises one cycle after `done` is sampled.
  - Request to response is therefore about 91 cycles.
- Back-to-back: the cycle after the RESP handshake is IDLE, so a pending request is acked in that cycle.
- Minimum spacing between consecutive `core_load` pulses is 4 cycles.
- The timeout counter is `$clog2(TIMEOUT)` bits wide. It never wraps, because it is compared and cleared.

## Structure
- A shared package `aes_pkg` holds:
  - the FSM state enum `arb_state_t` (IDLE, LOAD, WAIT, RESP);
  - the constant `AES_CORE_LATENCY` = 88.
- Sub-module `rr_arbiter`: parameter N; inputs `req[N-1:0]` and `ptr`; outputs `grant` (index) and `any`. It is combinational.
- The FSM, datapath registers and watchdog live in the top module.

## Test plan
- Single request (vector 1): requester 0, key `000102030405060708090a0b0c0d0e0f`, plaintext `00112233445566778899aabbccddeeff`.
  - Expect: `req_ack[0]` once; `core_load` one cycle later; `rsp_valid[0]` with `69c4e0d86a7b0430d8cdb78070b4c55a` and `rsp_error` = 0.
- Single request (vector 2): key `2b7e151628aed2a6abf7158809cf4f3c`, plaintext `3243f6a8885a308d313198a2e0370734`.
  - Expect: `3925841d02dc09fbdc118597196a0b32`.
- Simultaneous requests: both requesters request in the same cycle, N=2.
  - Expect: requester 0 is served first. Requester 1 is acked in the cycle after requester 0's response handshake.
  - Then re-raising both requests serves requester 1 first.
- Back-pressure: hold `rsp_ready` = 0 for 20 cycles.
  - Expect: `rsp_valid`/`rsp_ciphertext` stay stable and no `core_load` is issued.
  - Releasing `rsp_ready` completes the handshake.
- Hung core: a stub holds `core_done` at 0.
  - Expect: after TIMEOUT WAIT cycles, a one-cycle `core_reset`, then `rsp_valid` with `rsp_error` = 1 and ciphertext 0.
- Reset mid-WAIT: assert `reset_n` low at cycle 40 of WAIT.
  - Expect: all outputs immediately 0 except `core_reset`, and no response.
  - After release, a new request completes normally.
